// File: rtl/scope_trigger_capture.sv
// Trigger and capture controller for the LCD scope: arms on request, detects a
// level/slope trigger and strobes exactly DEPTH samples through the address counter.
module scope_trigger_capture #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 10,
  parameter int DEPTH   = 2**ADDR_W,
  parameter int HOLDOFF = 16,
  parameter int AUTO_TO = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              single,
  input  logic              auto_mode,
  input  logic              slope,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              smp_valid,
  input  logic [DATA_W-1:0] smp_data,
  input  logic [ADDR_W-1:0] cnt_value,
  output logic              cnt_en,
  output logic              cnt_clr,
  output logic              wr_en,
  output logic              busy,
  output logic              triggered,
  output logic              done,
  output logic [2:0]        dbg_state
);

  // The sample port is valid-only: each cycle with smp_valid=1 carries one sample
  // that is consumed in that cycle; there is no back-pressure toward the source.

  localparam int HO_W = $clog2(HOLDOFF) + 1;
  localparam int TO_W = $clog2(AUTO_TO) + 1;
  localparam logic [HO_W-1:0]   HO_LAST   = HO_W'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'((AUTO_TO > 0) ? AUTO_TO - 1 : 0);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLDOFF,
    S_WAIT_TRIG,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic              cnt_clr_q, cnt_clr_d;
  logic              busy_q, busy_d;
  logic              triggered_q, triggered_d;
  logic              done_q, done_d;
  logic [HO_W-1:0]   ho_cnt_q, ho_cnt_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [DATA_W-1:0] prev_q, prev_d;
  logic              prev_vld_q, prev_vld_d;
  logic [DATA_W-1:0] lvl_q, lvl_d;
  logic              cnt_en_c;

  logic rise_hit, fall_hit, trig_hit, timeout_hit;

  assign rise_hit    = prev_vld_q && (prev_q < lvl_q) && (smp_data >= lvl_q);
  assign fall_hit    = prev_vld_q && (prev_q > lvl_q) && (smp_data <= lvl_q);
  assign trig_hit    = slope ? fall_hit : rise_hit;
  // Timeout counter saturates at its terminal value, so a late auto_mode still fires.
  assign timeout_hit = auto_mode && (to_cnt_q == TO_LAST);

  always_comb begin
    state_d     = state_q;
    cnt_en_c    = 1'b0;
    cnt_clr_d   = 1'b0;
    triggered_d = triggered_q;
    ho_cnt_d    = ho_cnt_q;
    to_cnt_d    = to_cnt_q;
    prev_d      = prev_q;
    prev_vld_d  = prev_vld_q;
    lvl_d       = lvl_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        // Continuous mode re-arms itself one cycle after completion.
        if (arm || (state_q == S_DONE && !single)) begin
          lvl_d       = trig_level;
          cnt_clr_d   = 1'b1;
          triggered_d = 1'b0;
          ho_cnt_d    = '0;
          to_cnt_d    = '0;
          prev_vld_d  = 1'b0;
          state_d     = (HOLDOFF == 0) ? S_WAIT_TRIG : S_HOLDOFF;
        end
      end
      S_HOLDOFF: begin
        if (smp_valid) begin
          if (ho_cnt_q == HO_LAST) begin
            to_cnt_d   = '0;
            prev_vld_d = 1'b0;
            state_d    = S_WAIT_TRIG;
          end else begin
            ho_cnt_d = ho_cnt_q + 1'b1;
          end
        end
      end
      S_WAIT_TRIG: begin
        if (smp_valid) begin
          if (trig_hit || timeout_hit) begin
            cnt_en_c    = 1'b1;
            triggered_d = trig_hit;
            state_d     = S_CAPTURE;
          end else begin
            prev_d     = smp_data;
            prev_vld_d = 1'b1;
            if (to_cnt_q != TO_LAST) to_cnt_d = to_cnt_q + 1'b1;
          end
        end
      end
      S_CAPTURE: begin
        cnt_en_c = smp_valid;
        if (smp_valid && (cnt_value == LAST_ADDR)) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_HOLDOFF) || (state_d == S_WAIT_TRIG) || (state_d == S_CAPTURE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_clr_q   <= 1'b0;
      busy_q      <= 1'b0;
      triggered_q <= 1'b0;
      done_q      <= 1'b0;
      ho_cnt_q    <= '0;
      to_cnt_q    <= '0;
      prev_q      <= '0;
      prev_vld_q  <= 1'b0;
      lvl_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_clr_q   <= cnt_clr_d;
      busy_q      <= busy_d;
      triggered_q <= triggered_d;
      done_q      <= done_d;
      ho_cnt_q    <= ho_cnt_d;
      to_cnt_q    <= to_cnt_d;
      prev_q      <= prev_d;
      prev_vld_q  <= prev_vld_d;
      lvl_q       <= lvl_d;
    end
  end

  assign cnt_en    = cnt_en_c;
  assign wr_en     = cnt_en_c;
  assign cnt_clr   = cnt_clr_q;
  assign busy      = busy_q;
  assign triggered = triggered_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_scope_trigger_capture.sv
// Bench for scope_trigger_capture: a bench-side address counter and RAM, a sample-level
// reference model checked every cycle, directed scenarios and a randomized soak.
module tb_scope_trigger_capture;

  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 4;
  localparam int DEPTH   = 16;
  localparam int HOLDOFF = 2;
  localparam int AUTO_TO = 8;

  localparam int P_IDLE = 0, P_HOLD = 1, P_WAIT = 2, P_CAP = 3, P_DONE = 4;

  logic              clk, rst, arm, single, auto_mode, slope, smp_valid;
  logic [DATA_W-1:0] trig_level, smp_data;
  logic [ADDR_W-1:0] cnt_value;
  logic              cnt_en, cnt_clr, wr_en, busy, triggered, done;
  logic [2:0]        dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  int wr_total = 0;
  int clr_total = 0;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] exp_q [$];

  // Reference model: phase plus sample counts since arming/entry
  int ph, m_lvl, m_prev, m_have_prev, m_waited, m_seen, m_writes, m_trig, m_clr;

  int w0, c0, nd, prev_done, did_arm, vk, first_idx;
  logic a, v;

  scope_trigger_capture #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .HOLDOFF(HOLDOFF), .AUTO_TO(AUTO_TO)
  ) dut (
    .clk(clk), .rst(rst), .arm(arm), .single(single), .auto_mode(auto_mode),
    .slope(slope), .trig_level(trig_level), .smp_valid(smp_valid), .smp_data(smp_data),
    .cnt_value(cnt_value), .cnt_en(cnt_en), .cnt_clr(cnt_clr), .wr_en(wr_en),
    .busy(busy), .triggered(triggered), .done(done), .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream address counter (N=ADDR_W, Max=DEPTH-1)
  always @(posedge clk or negedge rst) begin
    if (!rst) cnt_value <= '0;
    else if (cnt_clr) cnt_value <= '0;
    else if (cnt_en) cnt_value <= (cnt_value == ADDR_W'(DEPTH - 1)) ? '0 : cnt_value + 1'b1;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    ph = P_IDLE; m_lvl = 0; m_prev = 0; m_have_prev = 0; m_waited = 0;
    m_seen = 0; m_writes = 0; m_trig = 0; m_clr = 0;
  endtask

  // Compare on the falling edge, then advance the model by the coming rising edge
  always @(negedge clk) begin : cmp
    int exp_en, hit;
    if (!rst) begin
      model_reset();
      check("rst_cnt_en", cnt_en, 0);
      check("rst_wr_en", wr_en, 0);
      check("rst_cnt_clr", cnt_clr, 0);
      check("rst_busy", busy, 0);
      check("rst_triggered", triggered, 0);
      check("rst_done", done, 0);
    end else begin
      hit = 0;
      exp_en = 0;
      if (ph == P_WAIT && smp_valid) begin
        if (slope) hit = m_have_prev && (m_prev > m_lvl) && (smp_data <= m_lvl);
        else       hit = m_have_prev && (m_prev < m_lvl) && (smp_data >= m_lvl);
        exp_en = hit || (auto_mode && (m_waited + 1 >= AUTO_TO));
      end else if (ph == P_CAP) begin
        exp_en = smp_valid;
      end
      check("cnt_en", cnt_en, exp_en);
      check("wr_en", wr_en, exp_en);
      check("cnt_clr", cnt_clr, m_clr);
      check("busy", busy, (ph == P_HOLD || ph == P_WAIT || ph == P_CAP));
      check("triggered", triggered, m_trig);
      check("done", done, (ph == P_DONE));
      if (exp_en) check("wr_addr", cnt_value, m_writes);
      if (wr_en) begin
        wr_total++;
        mem[cnt_value] = smp_data;
      end
      if (cnt_clr) clr_total++;

      m_clr = 0;
      case (ph)
        P_IDLE, P_DONE: begin
          if (arm || (ph == P_DONE && !single)) begin
            m_lvl = trig_level; m_clr = 1; m_trig = 0; m_seen = 0; m_writes = 0;
            if (HOLDOFF == 0) begin
              ph = P_WAIT; m_have_prev = 0; m_waited = 0;
            end else begin
              ph = P_HOLD;
            end
          end
        end
        P_HOLD: if (smp_valid) begin
          m_seen++;
          if (m_seen == HOLDOFF) begin
            ph = P_WAIT; m_have_prev = 0; m_waited = 0;
          end
        end
        P_WAIT: if (smp_valid) begin
          if (exp_en != 0) begin
            m_trig = hit; m_writes = 1; ph = P_CAP;
          end else begin
            m_prev = smp_data; m_have_prev = 1; m_waited++;
          end
        end
        P_CAP: if (smp_valid) begin
          m_writes++;
          if (m_writes == DEPTH) ph = P_DONE;
        end
        default: ph = P_IDLE;
      endcase
    end
  end

  task automatic drive(input logic a_i, input logic v_i, input logic [DATA_W-1:0] d_i);
    arm = a_i; smp_valid = v_i; smp_data = d_i;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  endtask

  task automatic reset_pulse();
    rst = 1'b0; arm = 1'b0;
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 8'h00);
    rst = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    clear_mem();
    rst = 1'b1; arm = 1'b0; single = 1'b1; auto_mode = 1'b0; slope = 1'b0;
    trig_level = '0; smp_valid = 1'b0; smp_data = '0;
    #2 rst = 1'b0;

    // 1: reset holds everything low while inputs toggle; no arm means no activity
    for (int i = 0; i < 6; i++) begin
      single = 1'($urandom_range(0, 1)); auto_mode = 1'($urandom_range(0, 1));
      slope = 1'($urandom_range(0, 1)); trig_level = 8'($urandom_range(0, 255));
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
    end
    check("t1_wr_in_rst", wr_en, 0);
    check("t1_done_in_rst", done, 0);
    single = 1'b1; auto_mode = 1'b0; slope = 1'b0; arm = 1'b0;
    rst = 1'b1;
    w0 = wr_total;
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 8'($urandom_range(0, 255)));
    check("t1_no_writes", wr_total - w0, 0);
    check("t1_busy", busy, 0);

    // 2: rising trigger on a ramp
    trig_level = 8'h80; slope = 1'b0;
    clear_mem(); w0 = wr_total;
    drive(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 24; i++) drive(1'b0, 1'b1, 8'(8'h70 + 4 * i));
    check("t2_writes", wr_total - w0, 16);
    check("t2_triggered", triggered, 1);
    check("t2_done", done, 1);
    check("t2_busy", busy, 0);
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(8'(8'h80 + 4 * i));
    for (int i = 0; i < DEPTH; i++) check("t2_mem", mem[i], exp_q.pop_front());

    // 3: falling trigger including equality; 0x80 then 0x70 must not fire
    slope = 1'b1;
    clear_mem(); w0 = wr_total;
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b0, 1'b1, 8'h55);
    drive(1'b0, 1'b1, 8'h55);
    drive(1'b0, 1'b1, 8'h80);
    drive(1'b0, 1'b1, 8'h70);
    check("t3_no_early_trig", wr_total - w0, 0);
    drive(1'b0, 1'b1, 8'h90);
    drive(1'b0, 1'b1, 8'h80);
    for (int i = 0; i < 20; i++) drive(1'b0, 1'b1, 8'(8'h7F - i));
    check("t3_writes", wr_total - w0, 16);
    check("t3_mem0", mem[0], 8'h80);
    check("t3_mem1", mem[1], 8'h7F);
    check("t3_mem15", mem[15], 8'h71);
    check("t3_triggered", triggered, 1);

    // 4: auto timeout forces capture; without auto it waits indefinitely
    slope = 1'b0; trig_level = 8'h80; auto_mode = 1'b1;
    w0 = wr_total; first_idx = -1;
    drive(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 30; i++) begin
      drive(1'b0, 1'b1, 8'h10);
      if (first_idx < 0 && (wr_total - w0) > 0) first_idx = i;
    end
    check("t4_first_write_idx", first_idx, 9);
    check("t4_writes", wr_total - w0, 16);
    check("t4_triggered", triggered, 0);
    check("t4_done", done, 1);
    auto_mode = 1'b0;
    w0 = wr_total;
    drive(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 100; i++) drive(1'b0, 1'b1, 8'h10);
    check("t4_noauto_writes", wr_total - w0, 0);
    check("t4_noauto_busy", busy, 1);
    check("t4_noauto_done", done, 0);
    reset_pulse();

    // 5: continuous mode with every-other-cycle valid and an ignored arm in capture
    single = 1'b0; slope = 1'b0; trig_level = 8'h80;
    w0 = wr_total; c0 = clr_total; nd = 0; prev_done = 0; did_arm = 0; vk = 0;
    drive(1'b1, 1'b0, 8'h00);
    for (int k = 0; k < 600 && nd < 2; k++) begin
      a = 1'b0;
      if (ph == P_CAP && did_arm == 0) begin
        a = 1'b1; did_arm = 1;
      end
      v = (k % 2 == 1);
      if (v) vk++;
      drive(a, v, 8'(vk * 37));
      if (done && prev_done == 0) nd++;
      prev_done = done;
    end
    check("t5_captures", nd, 2);
    check("t5_writes", wr_total - w0, 32);
    check("t5_clr_pulses", clr_total - c0, 2);

    // 6: reset in the middle of a capture, then a clean full capture
    single = 1'b1;
    reset_pulse();
    trig_level = 8'h80; slope = 1'b0;
    w0 = wr_total;
    drive(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 40 && (wr_total - w0) < 5; i++) drive(1'b0, 1'b1, 8'(8'h70 + 4 * i));
    check("t6_five_writes", wr_total - w0, 5);
    arm = 1'b0; smp_valid = 1'b1; smp_data = 8'h94;
    #1;
    check("t6_wr_before_rst", wr_en, 1);
    rst = 1'b0;
    #1;
    check("t6_wr_after_rst", wr_en, 0);
    check("t6_en_after_rst", cnt_en, 0);
    check("t6_state_idle", dbg_state, 0);
    check("t6_busy_after_rst", busy, 0);
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 8'h00);
    rst = 1'b1;
    clear_mem(); w0 = wr_total;
    drive(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 24; i++) drive(1'b0, 1'b1, 8'(8'h70 + 4 * i));
    check("t6_full_writes", wr_total - w0, 16);
    check("t6_mem0", mem[0], 8'h80);
    check("t6_mem15", mem[15], 8'hBC);
    check("t6_done", done, 1);

    // 7: randomized soak against the model
    for (int blk = 0; blk < 12; blk++) begin
      single = 1'($urandom_range(0, 1)); auto_mode = 1'($urandom_range(0, 1));
      slope = 1'($urandom_range(0, 1)); trig_level = 8'($urandom_range(0, 255));
      drive(1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
      for (int i = 0; i < 60; i++)
        drive(1'($urandom_range(0, 29) == 0), 1'($urandom_range(0, 3) != 0),
              8'($urandom_range(0, 255)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
